// File: rtl/vga_timing_pkg.sv
// Shared raster defaults and coordinate type for the 640x480@60 timing generator.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL  = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL  = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int HS_START = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int HS_END   = HS_START + H_SYNC_DEF;
    localparam int VS_START = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int VS_END   = VS_START + V_SYNC_DEF;

    // Half-open window test lo <= v < hi, used for every region decode.
    function automatic logic in_window(input coord_t v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Parameterised 1-bit shift register with a synchronous reset value.
module sync_delay_line #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage_reg;
    logic [DEPTH-1:0] stage_next;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_next[gi] = d;
            end else begin : g_tail
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            stage_reg <= {DEPTH{RESET_VAL}};
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: DrawX/DrawY, blank, hs/vs and frame/line strobes.
// Define VGA_SYNC_ALIGN_EN to delay hs/vs by SYNC_DELAY cycles through sync_delay_line.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE_DEF,
    parameter int H_FRONT    = vga_timing_pkg::H_FRONT_DEF,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC_DEF,
    parameter int H_BACK     = vga_timing_pkg::H_BACK_DEF,
    parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE_DEF,
    parameter int V_FRONT    = vga_timing_pkg::V_FRONT_DEF,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC_DEF,
    parameter int V_BACK     = vga_timing_pkg::V_BACK_DEF,
    parameter int SYNC_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       Reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       sync,
    output logic       frame_start,
    output logic       line_start
);

    localparam int     LINE_LEN    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int     FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int     HSYNC_FIRST = H_VISIBLE + H_FRONT;
    localparam int     HSYNC_END   = HSYNC_FIRST + H_SYNC;
    localparam int     VSYNC_FIRST = V_VISIBLE + V_FRONT;
    localparam int     VSYNC_END   = VSYNC_FIRST + V_SYNC;
    localparam coord_t H_LAST      = coord_t'(LINE_LEN - 1);
    localparam coord_t V_LAST      = coord_t'(FRAME_LINES - 1);

    generate
        if (LINE_LEN > 1024 || FRAME_LINES > 1024) begin : g_bad_total
            $error("vga_timing_gen: raster totals exceed 10-bit counters");
        end
        if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be 1..4");
        end
    endgenerate

    coord_t hc_reg, vc_reg;
    coord_t hc_next, vc_next;
    logic   blank_reg, hs_reg, vs_reg, frame_start_reg, line_start_reg;

    always_comb begin
        hc_next = (hc_reg == H_LAST) ? '0 : hc_reg + 1'b1;
        vc_next = vc_reg;
        if (hc_reg == H_LAST) begin
            vc_next = (vc_reg == V_LAST) ? '0 : vc_reg + 1'b1;
        end
    end

    // Decoding the next count keeps every strobe aligned with DrawX/DrawY.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            hc_reg          <= H_LAST;
            vc_reg          <= V_LAST;
            blank_reg       <= 1'b0;
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
        end else begin
            hc_reg          <= hc_next;
            vc_reg          <= vc_next;
            blank_reg       <= in_window(hc_next, 0, H_VISIBLE) && in_window(vc_next, 0, V_VISIBLE);
            hs_reg          <= !in_window(hc_next, HSYNC_FIRST, HSYNC_END);
            vs_reg          <= !in_window(vc_next, VSYNC_FIRST, VSYNC_END);
            frame_start_reg <= (hc_next == '0) && (vc_next == '0);
            line_start_reg  <= (hc_next == '0) && in_window(vc_next, 0, V_VISIBLE);
        end
    end

    assign DrawX       = hc_reg;
    assign DrawY       = vc_reg;
    assign blank       = blank_reg;
    assign frame_start = frame_start_reg;
    assign line_start  = line_start_reg;
    assign sync        = 1'b0;

`ifdef VGA_SYNC_ALIGN_EN
    // Syncs lag to match the mappers' address -> ROM -> colour register pipeline.
    sync_delay_line #(.DEPTH(SYNC_DELAY), .RESET_VAL(1'b1)) u_hs_delay (
        .clk  (vga_clk),
        .srst (Reset),
        .d    (hs_reg),
        .q    (hs)
    );
    sync_delay_line #(.DEPTH(SYNC_DELAY), .RESET_VAL(1'b1)) u_vs_delay (
        .clk  (vga_clk),
        .srst (Reset),
        .d    (vs_reg),
        .q    (vs)
    );
`else
    assign hs = hs_reg;
    assign vs = vs_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 640x480 instance and a shrunken raster instance for whole-frame checks.
module tb_vga_timing_gen;

    localparam int SD = 2;
`ifdef VGA_SYNC_ALIGN_EN
    localparam int LAG = SD;
`else
    localparam int LAG = 0;
`endif
    localparam int SH_V = 40, SH_F = 4, SH_S = 8, SH_B = 4;
    localparam int SV_V = 30, SV_F = 3, SV_S = 2, SV_B = 5;
    localparam int S_HT = SH_V + SH_F + SH_S + SH_B;
    localparam int S_VT = SV_V + SV_F + SV_S + SV_B;

    logic       vga_clk = 1'b0;
    logic       Reset   = 1'b1;
    logic [9:0] dx_d, dy_d, dx_s, dy_s;
    logic       bl_d, hs_d, vs_d, sy_d, fs_d, ls_d;
    logic       bl_s, hs_s, vs_s, sy_s, fs_s, ls_s;

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen #(.SYNC_DELAY(SD)) dut_d (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(dx_d), .DrawY(dy_d), .blank(bl_d),
        .hs(hs_d), .vs(vs_d), .sync(sy_d), .frame_start(fs_d), .line_start(ls_d)
    );

    vga_timing_gen #(
        .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B), .SYNC_DELAY(SD)
    ) dut_s (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(dx_s), .DrawY(dy_s), .blank(bl_s),
        .hs(hs_s), .vs(vs_s), .sync(sy_s), .frame_start(fs_s), .line_start(ls_s)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic blank, hs, vs, sync, fs, ls;
    } obs_t;

    typedef struct {
        int hv, hf, hsn, hb, vv, vf, vsn, vb;
        int hc, vc;
        logic blank, hsu, vsu, fs, ls;
        logic [3:0] hp, vp;
    } mdl_t;

    obs_t q_d[$];
    obs_t q_s[$];
    mdl_t md, ms;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic rst_at_edge;

    int   hs_run, vs_run, ls_cnt, last_fs;
    logic hs_prev, bl_prev, vs_prev, fs_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic mdl_t mdl_step(input mdl_t m, input logic rst);
        mdl_t r;
        int   ht, vt;
        r  = m;
        ht = m.hv + m.hf + m.hsn + m.hb;
        vt = m.vv + m.vf + m.vsn + m.vb;
        if (rst) begin
            r.hc = ht - 1;  r.vc = vt - 1;
            r.blank = 1'b0; r.hsu = 1'b1; r.vsu = 1'b1; r.fs = 1'b0; r.ls = 1'b0;
            r.hp = '1;      r.vp = '1;
        end else begin
            r.hp    = {m.hp[2:0], m.hsu};
            r.vp    = {m.vp[2:0], m.vsu};
            r.hc    = (m.hc == ht - 1) ? 0 : m.hc + 1;
            r.vc    = (m.hc == ht - 1) ? ((m.vc == vt - 1) ? 0 : m.vc + 1) : m.vc;
            r.blank = (r.hc < m.hv) && (r.vc < m.vv);
            r.hsu   = !((r.hc >= m.hv + m.hf) && (r.hc < m.hv + m.hf + m.hsn));
            r.vsu   = !((r.vc >= m.vv + m.vf) && (r.vc < m.vv + m.vf + m.vsn));
            r.fs    = (r.hc == 0) && (r.vc == 0);
            r.ls    = (r.hc == 0) && (r.vc < m.vv);
        end
        return r;
    endfunction

    function automatic obs_t mdl_obs(input mdl_t m);
        obs_t o;
        o.x     = 10'(m.hc);
        o.y     = 10'(m.vc);
        o.blank = m.blank;
        o.hs    = (LAG > 0) ? m.hp[SD-1] : m.hsu;
        o.vs    = (LAG > 0) ? m.vp[SD-1] : m.vsu;
        o.sync  = 1'b0;
        o.fs    = m.fs;
        o.ls    = m.ls;
        return o;
    endfunction

    task automatic clear_trackers();
        hs_run = 0; vs_run = 0; ls_cnt = 0; fs_seen = 1'b0;
    endtask

    task automatic track();
        if (rst_at_edge) begin
            clear_trackers();
        end else begin
            if (!hs_d) begin
                if (hs_prev) check("dflt_hs_fall_x", 32'(dx_d), 32'(656 + LAG));
                hs_run++;
            end else if (hs_run > 0) begin
                check("dflt_hs_width", 32'(hs_run), 32'd96);
                hs_run = 0;
            end
            if (bl_prev && !bl_d) check("dflt_blank_fall_x", 32'(dx_d), 32'd640);
            if (dx_d == 10'd0 && dy_d == 10'd1) check("dflt_ls_line1", 32'(ls_d), 32'd1);
            if (!vs_s) begin
                if (vs_prev) check("sml_vs_fall_y", 32'(dy_s), 32'(SV_V + SV_F));
                vs_run++;
            end else if (vs_run > 0) begin
                check("sml_vs_width", 32'(vs_run), 32'(SV_S * S_HT));
                vs_run = 0;
            end
            if (fs_s) begin
                if (fs_seen) begin
                    check("sml_frame_period", 32'(cyc - last_fs), 32'(S_HT * S_VT));
                    check("sml_line_starts", 32'(ls_cnt), 32'(SV_V));
                    $display("frame boundary at cycle %0d, line_start count %0d", cyc, ls_cnt);
                end
                fs_seen = 1'b1;
                last_fs = cyc;
                ls_cnt  = 0;
            end
            if (ls_s) ls_cnt++;
        end
        hs_prev = hs_d;
        bl_prev = bl_d;
        vs_prev = vs_s;
    endtask

    task automatic step();
        obs_t od, os;
        @(posedge vga_clk);
        rst_at_edge = Reset;
        md = mdl_step(md, Reset);
        ms = mdl_step(ms, Reset);
        q_d.push_back(mdl_obs(md));
        q_s.push_back(mdl_obs(ms));
        @(negedge vga_clk);
        cyc++;
        od = {dx_d, dy_d, bl_d, hs_d, vs_d, sy_d, fs_d, ls_d};
        os = {dx_s, dy_s, bl_s, hs_s, vs_s, sy_s, fs_s, ls_s};
        check("dflt_cycle", 32'(od), 32'(q_d.pop_front()));
        check("sml_cycle", 32'(os), 32'(q_s.pop_front()));
        track();
    endtask

    task automatic check_reset_state();
        check("rst_x", 32'(dx_d), 32'd799);
        check("rst_y", 32'(dy_d), 32'd524);
        check("rst_blank", 32'(bl_d), 32'd0);
        check("rst_hs", 32'(hs_d), 32'd1);
        check("rst_vs", 32'(vs_d), 32'd1);
        check("rst_fs", 32'(fs_d), 32'd0);
        $display("reset state: DrawX=%0d DrawY=%0d blank=%0b hs=%0b vs=%0b", dx_d, dy_d, bl_d, hs_d, vs_d);
    endtask

    task automatic check_first_pixel();
        check("start_x", 32'(dx_d), 32'd0);
        check("start_y", 32'(dy_d), 32'd0);
        check("start_blank", 32'(bl_d), 32'd1);
        check("start_fs", 32'(fs_d), 32'd1);
        check("start_sml_fs", 32'(fs_s), 32'd1);
        $display("first pixel: DrawX=%0d DrawY=%0d blank=%0b frame_start=%0b", dx_d, dy_d, bl_d, fs_d);
    endtask

    initial begin
        md = '{hv:640, hf:16, hsn:96, hb:48, vv:480, vf:10, vsn:2, vb:33,
               hc:0, vc:0, blank:1'b0, hsu:1'b1, vsu:1'b1, fs:1'b0, ls:1'b0, hp:'1, vp:'1};
        ms = '{hv:SH_V, hf:SH_F, hsn:SH_S, hb:SH_B, vv:SV_V, vf:SV_F, vsn:SV_S, vb:SV_B,
               hc:0, vc:0, blank:1'b0, hsu:1'b1, vsu:1'b1, fs:1'b0, ls:1'b0, hp:'1, vp:'1};
        clear_trackers();
        hs_prev = 1'b1; bl_prev = 1'b0; vs_prev = 1'b1; last_fs = 0;

        Reset = 1'b1;
        repeat (3) step();
        check_reset_state();
        Reset = 1'b0;
        step();
        check_first_pixel();

        repeat (2 * S_HT * S_VT + 200) step();

        for (int i = 0; i < 1000 && dx_d != 10'd700; i++) step();
        check("wait_x700", 32'(dx_d), 32'd700);
        $display("mid-frame reset at DrawX=%0d DrawY=%0d hs=%0b", dx_d, dy_d, hs_d);
        Reset = 1'b1;
        step();
        check_reset_state();
        Reset = 1'b0;
        step();
        check_first_pixel();

        repeat (S_HT * S_VT + 100) step();

        check("queue_drained", 32'(q_d.size() + q_s.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
